semafor_fifo: RTL and testbench
===============================

Name: semafor_fifo

Overview:
- Parametrised successor to the single-bit, single-slot semafor mailbox: a WIDTH-bit, DEPTH-entry writer/reader handshake buffer on one clock.
- Sits between PLC CPU producer and consumer stages: writer and reader each see a ready flag; the reader's consume is additionally qualified by REAL.
- Keeps the toggle-flag full/empty scheme, generalised to wrap-bit pointers, plus an occupancy count and an almost-full flag.

Parameters:
- WIDTH, 1, data word width in bits (>=1).
- DEPTH, 4, number of slots; power of two, >=2.
- AF_LEVEL, DEPTH-1, AFULL asserts when COUNT >= AF_LEVEL (1..DEPTH).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on CLK rising edge.
- DI  in  WIDTH  write data.
- WR  in  1  write request.
- WR_EN  in  1  writer-side enable; gates WR_RDY.
- RD  in  1  read request.
- RD_EN  in  1  reader-side enable; gates RD_RDY.
- REAL  in  1  read qualifier; a read consumes only when REAL=1.
- DQ  out  WIDTH  head-of-queue data, first-word fall-through.
- WR_RDY  out  1  slot free and WR_EN.
- RD_RDY  out  1  data present and RD_EN.
- COUNT  out  clog2(DEPTH)+1  occupied slots, 0..DEPTH.
- AFULL  out  1  COUNT >= AF_LEVEL.

Behaviour:
- AW = clog2(DEPTH). Write pointer WP and read pointer RP are AW+1 bits each; the MSB is the wrap/toggle bit.
- empty = (WP == RP). full = (WP[AW] != RP[AW]) and (WP[AW-1:0] == RP[AW-1:0]).
- WR_RDY = ~full & WR_EN. RD_RDY = ~empty & RD_EN. Both are combinational from registered state; REAL is excluded from both.
- Write fire: WE = WR & WR_RDY. On the next edge, mem[WP[AW-1:0]] <= DI and WP <= WP+1.
- Read fire: RE = REAL & RD & RD_RDY. On the next edge, RP <= RP+1.
- DQ = mem[RP[AW-1:0]], combinational (FWFT). DQ is meaningful only while ~empty; when empty it holds the stale slot value.
- Write-to-read latency: 1 cycle. Data written at edge N shows RD_RDY=1 and valid DQ after edge N.
- COUNT is registered: +1 on WE only, -1 on RE only, unchanged on both or neither. COUNT == WP-RP always. AFULL is derived from COUNT.
- Simultaneous WE and RE: both fire, COUNT unchanged.
- No bypass:
  - When full, a write is refused even if a read fires in the same cycle.
  - When empty, a read is refused even if a write fires in the same cycle.
- Requests while not ready (WR with full, RD with empty, RD without REAL) are ignored with no state change.
- Pointer wrap: the 2^(AW+1) modular increment flips the toggle bit every DEPTH operations.
- Reset (RST_N=0 at an edge): WP=0, RP=0, COUNT=0. Resulting outputs: WR_RDY=WR_EN, RD_RDY=0, AFULL=0 (AF_LEVEL>=1). Memory contents are not reset.
- Reset mid-operation discards all queued data; a WE/RE in the reset cycle has no effect.

Optional Feature:
- Macro SEMAFOR_FIFO_FLAGS_EN. When defined, two outputs are added:
  - OVF (out, 1): sticky; set when WR & WR_EN & full.
  - UNF (out, 1): sticky; set when REAL & RD & RD_EN & empty.
  - Both clear only on reset (reset value 0).
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package plc_pkg: function clog2, and localparams for pointer width (AW+1) and count width.
- One natural sub-module, semafor_ptr: the AW+1-bit wrap pointer with increment enable and synchronous active-low clear. Instantiated twice, for WP and RP.
- Memory stays inline as a register array.

Test Plan:
- Reset with WR_EN=1, RD_EN=1: after RST_N low for 1 edge -> COUNT=0, WR_RDY=1, RD_RDY=0, AFULL=0.
- WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 on consecutive cycles -> COUNT=4, WR_RDY=0, AFULL=1 at COUNT=3. A fifth write of 0x55 is ignored.
- From full, read with REAL=1 four cycles -> DQ sequence 0x11,0x22,0x33,0x44; COUNT ends at 0, RD_RDY=0.
- RD=1, RD_EN=1, REAL=0 with COUNT=2 -> no consume: COUNT stays 2, DQ unchanged. Then REAL=1 -> consumes one.
- Simultaneous WR/RD at COUNT=2 for 10 cycles (pointers wrap twice) -> COUNT stays 2 and the data order is preserved. Simultaneous at COUNT=4 -> read fires, write refused, COUNT=3.
- With SEMAFOR_FIFO_FLAGS_EN: write at full -> OVF=1 and held. Read at empty -> UNF=1. Both clear only after RST_N=0.

Source files
------------

// File: rtl/plc_pkg.sv
// Shared helpers for the PLC handshake buffers: ceiling log2 and the
// pointer/count width rules derived from a slot count.
package plc_pkg;

  localparam int PLC_WIDTH_DEFAULT = 1;
  localparam int PLC_DEPTH_DEFAULT = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // One extra MSB on the pointer serves as the wrap/toggle bit.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Count must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/semafor_ptr.sv
// Wrap pointer for semafor_fifo: modular increment with a toggle MSB and a
// synchronous active-low clear that dominates the increment.
module semafor_ptr #(
  parameter int PW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/semafor_fifo.sv
// WIDTH x DEPTH first-word-fall-through handshake buffer with toggle-bit
// full/empty, registered occupancy and almost-full. SEMAFOR_FIFO_FLAGS_EN adds sticky OVF/UNF.
module semafor_fifo
  import plc_pkg::*;
#(
  parameter int WIDTH    = PLC_WIDTH_DEFAULT,
  parameter int DEPTH    = PLC_DEPTH_DEFAULT,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [WIDTH-1:0]              DI,
  input  logic                          WR,
  input  logic                          WR_EN,
  input  logic                          RD,
  input  logic                          RD_EN,
  input  logic                          REAL,
  output logic [WIDTH-1:0]              DQ,
  output logic                          WR_RDY,
  output logic                          RD_RDY,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                          AFULL
`ifdef SEMAFOR_FIFO_FLAGS_EN
  ,
  output logic                          OVF,
  output logic                          UNF
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             empty;
  logic             full;
  logic             we;
  logic             re;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  // REAL only qualifies the consume; the ready flags never look at it.
  assign WR_RDY = ~full & WR_EN;
  assign RD_RDY = ~empty & RD_EN;
  assign we     = WR & WR_RDY;
  assign re     = REAL & RD & RD_RDY;

  semafor_ptr #(.PW(PW)) u_wp (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .inc_i (we),
    .ptr_o (wp)
  );

  semafor_ptr #(.PW(PW)) u_rp (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .inc_i (re),
    .ptr_o (rp)
  );

  always_ff @(posedge CLK) begin
    if (RST_N && we) begin
      mem_q[wp[AW-1:0]] <= DI;
    end
  end

  assign DQ = mem_q[rp[AW-1:0]];

  always_comb begin
    count_d = count_q;
    case ({we, re})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;
  assign AFULL = (count_q >= CW'(AF_LEVEL));

`ifdef SEMAFOR_FIFO_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Refused requests latch until the next reset so software can poll them.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (WR & WR_EN & full) begin
        ovf_q <= 1'b1;
      end
      if (REAL & RD & RD_EN & empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;
`endif

endmodule

// File: tb/tb_semafor_fifo.sv
// Scoreboard bench for semafor_fifo (WIDTH=8, DEPTH=4): directed plan followed by
// randomized traffic, checked against a queue-based model of the buffer.
module tb_semafor_fifo;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = DEPTH - 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic [WIDTH-1:0] di;
  logic             wr;
  logic             wrEn;
  logic             rd;
  logic             rdEn;
  logic             tbReal;
  logic [WIDTH-1:0] dq;
  logic             wrRdy;
  logic             rdRdy;
  logic [2:0]       count;
  logic             afull;
`ifdef SEMAFOR_FIFO_FLAGS_EN
  logic             ovf;
  logic             unf;
`endif

  always #5 clk = ~clk;

  semafor_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .CLK   (clk),
    .RST_N (rstN),
    .DI    (di),
    .WR    (wr),
    .WR_EN (wrEn),
    .RD    (rd),
    .RD_EN (rdEn),
    .REAL  (tbReal),
    .DQ    (dq),
    .WR_RDY(wrRdy),
    .RD_RDY(rdRdy),
    .COUNT (count),
    .AFULL (afull)
`ifdef SEMAFOR_FIFO_FLAGS_EN
    ,
    .OVF   (ovf),
    .UNF   (unf)
`endif
  );

  typedef struct {
    bit check;
    bit inReset;
    int cnt;
    bit wrRdy;
    bit rdRdy;
    bit afull;
    bit ovf;
    bit unf;
  } cycExp_t;

  cycExp_t          cycQ[$];
  logic [WIDTH-1:0] dataQ[$];

  int checks = 0;
  int errors = 0;

  int mCount = 0;
  bit mOvf   = 1'b0;
  bit mUnf   = 1'b0;
  bit known  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive the pins, record what the outputs must show
  // before the coming edge, then advance the model across that edge.
  task automatic applyStimulus(input bit rs, input bit w, input bit we, input bit r,
                               input bit re, input bit rl, input logic [WIDTH-1:0] d);
    cycExp_t e;
    bit wf;
    bit rf;
    @(negedge clk);
    rstN   = rs;
    wr     = w;
    wrEn   = we;
    rd     = r;
    rdEn   = re;
    tbReal = rl;
    di     = d;
    e.check   = known;
    e.inReset = !rs;
    e.cnt     = mCount;
    e.wrRdy   = we && (mCount < DEPTH);
    e.rdRdy   = re && (mCount > 0);
    e.afull   = (mCount >= AF_LEVEL);
    e.ovf     = mOvf;
    e.unf     = mUnf;
    cycQ.push_back(e);
    if (!rs) begin
      mCount = 0;
      mOvf   = 1'b0;
      mUnf   = 1'b0;
      dataQ.delete();
      known  = 1'b1;
    end else begin
      wf = w && we && (mCount < DEPTH);
      rf = rl && r && re && (mCount > 0);
      if (w && we && (mCount == DEPTH)) mOvf = 1'b1;
      if (rl && r && re && (mCount == 0)) mUnf = 1'b1;
      if (wf) dataQ.push_back(d);
      mCount = mCount + (wf ? 1 : 0) - (rf ? 1 : 0);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    cycExp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (cycQ.size() > 0) begin
        e = cycQ.pop_front();
        if (e.check) begin
          checkOutput("count", 32'(count), 32'(e.cnt));
          checkOutput("wr_rdy", 32'(wrRdy), 32'(e.wrRdy));
          checkOutput("rd_rdy", 32'(rdRdy), 32'(e.rdRdy));
          checkOutput("afull", 32'(afull), 32'(e.afull));
`ifdef SEMAFOR_FIFO_FLAGS_EN
          checkOutput("ovf", 32'(ovf), 32'(e.ovf));
          checkOutput("unf", 32'(unf), 32'(e.unf));
`endif
        end
        if (e.check && !e.inReset && rdRdy) begin
          if (dataQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dq_unexpected rd_rdy=1 but no data expected at %0t", $time);
          end else begin
            checkOutput("dq", 32'(dq), 32'(dataQ[0]));
            if (tbReal && rd) void'(dataQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] fillVals [5];
    bit rs, w, we, r, re, rl;
    int wrPct;
    fillVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rstN = 1'b0; wr = 1'b0; wrEn = 1'b0; rd = 1'b0; rdEn = 1'b0; tbReal = 1'b0; di = '0;

    $display("[TB] reset and fill/drain");
    applyStimulus(0, 0, 1, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 1, 0, 8'h00);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0, 1, 0, fillVals[i]);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 1, 1, 8'h00);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);

    $display("[TB] read qualifier");
    applyStimulus(1, 1, 1, 0, 1, 0, 8'hA1);
    applyStimulus(1, 1, 1, 0, 1, 0, 8'hA2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 1, 0, 8'h00);
    applyStimulus(1, 0, 1, 1, 1, 1, 8'h00);
    applyStimulus(1, 1, 1, 0, 1, 0, 8'hA3);

    $display("[TB] simultaneous traffic and full boundary");
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 1, 1, 1, 8'hB0 + 8'(i));
    applyStimulus(1, 1, 1, 0, 1, 0, 8'hC1);
    applyStimulus(1, 1, 1, 0, 1, 0, 8'hC2);
    applyStimulus(1, 1, 1, 1, 1, 1, 8'hC3);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 1, 1, 8'h00);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);

    $display("[TB] sticky flags and reset clear");
    applyStimulus(0, 0, 1, 0, 1, 0, 8'h00);
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      wrPct = ((i / 300) % 2 == 0) ? 80 : 30;
      rs = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < wrPct);
      we = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 99) < 110 - wrPct);
      re = ($urandom_range(0, 9) != 0);
      rl = ($urandom_range(0, 3) != 0);
      applyStimulus(rs, w, we, r, re, rl, 8'($urandom));
    end
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00);

    @(posedge clk);
    #1;
    checkOutput("cycq_drain", 32'(cycQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
